// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requests feeding a small in-order buffer.
// Optional `FETCH_PERF_COUNT_EN adds a consumed-instruction counter on fetch_count.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [3:0]  opcode,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] fetch_count
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, STALL} state_e;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic               discard_q, discard_d;
    logic [CNT_W-1:0]   count_q, count_d, count_nxt;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    entry_t             buf_q [BUF_DEPTH];
    entry_t             head;
    logic               accept, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A discard in flight counts as the one outstanding request, so it blocks issue.
    assign imem_req    = (state_q == FETCH) && !discard_q && (count_q < CNT_W'(BUF_DEPTH));
    assign imem_addr   = pc_q;
    assign accept      = imem_req && imem_ready;
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;
    assign push        = (state_q == WAIT) && imem_rvalid && !discard_q && !branch_taken;

    assign head     = buf_q[rd_ptr_q];
    assign instr    = instr_valid ? head.word : '0;
    assign instr_pc = instr_valid ? head.pc : '0;
    assign opcode   = instr[31:28];

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_nxt  = count_q;
        if (push && !pop) count_nxt = count_q + CNT_W'(1);
        if (pop && !push) count_nxt = count_q - CNT_W'(1);
        count_d    = count_nxt;

        unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (accept) begin
                    state_d    = WAIT;
                    pc_d       = pc_q + 32'd4;
                    req_addr_d = pc_q;
                end
            end
            WAIT: begin
                if (imem_rvalid)
                    state_d = (count_nxt < CNT_W'(BUF_DEPTH)) ? FETCH : STALL;
            end
            STALL: begin
                if (count_nxt < CNT_W'(BUF_DEPTH)) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        if (discard_q && imem_rvalid) discard_d = 1'b0;

        // Redirect wins over everything: flush, retarget, and poison whatever is in flight.
        if (branch_taken) begin
            state_d   = FETCH;
            pc_d      = branch_target & ~32'h3;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            discard_d = accept
                     || ((state_q == WAIT) && !imem_rvalid)
                     || (discard_q && !imem_rvalid);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            discard_q  <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // NOTE: buffer storage has no reset; outputs are gated by instr_valid instead.
    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr_q] <= '{word: imem_rdata, pc: req_addr_q};
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  fetch_count_q <= '0;
        else if (pop)  fetch_count_q <= fetch_count_q + 32'd1;
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, latency, stall, redirect/discard, wrap,
// mid-transaction reset and the consumed-instruction counter.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [3:0]  opcode;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

`ifdef FETCH_PERF_COUNT_EN
    localparam logic [31:0] EXP_CNT = 32'd100;
`else
    localparam logic [31:0] EXP_CNT = 32'd0;
`endif

    fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: answers one cycle after acceptance with data = address + 1.
    logic        mem_auto;
    logic        auto_rvalid = 1'b0;
    logic [31:0] auto_rdata  = 32'd0;
    logic        man_rvalid;
    logic [31:0] man_rdata;
    logic        resp_acc;
    logic [31:0] resp_addr;

    always @(posedge clk) begin
        resp_acc  = imem_req && imem_ready;
        resp_addr = imem_addr;
        #1;
        auto_rvalid = resp_acc;
        auto_rdata  = resp_acc ? resp_addr + 32'd1 : 32'd0;
    end

    assign imem_rvalid = mem_auto ? auto_rvalid : man_rvalid;
    assign imem_rdata  = mem_auto ? auto_rdata  : man_rdata;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int pops;
        int cyc;
        logic [31:0] exp_pc;

        reset_n       = 1'b0;
        imem_ready    = 1'b1;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        mem_auto      = 1'b1;
        man_rvalid    = 1'b0;
        man_rdata     = 32'd0;

        #2;
        tick();
        tick();
        check("rst_req",    {31'd0, imem_req},    32'd0);
        check("rst_addr",   imem_addr,            32'd0);
        check("rst_valid",  {31'd0, instr_valid}, 32'd0);
        check("rst_instr",  instr,                32'd0);
        check("rst_pc",     instr_pc,             32'd0);
        check("rst_opcode", {28'd0, opcode},      32'd0);
        check("rst_count",  fetch_count,          32'd0);

        // Zero-wait latency: IDLE, FETCH, WAIT, then valid.
        reset_n = 1'b1;
        tick();
        check("lat1_req",   {31'd0, imem_req},    32'd1);
        check("lat1_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("lat2_req",   {31'd0, imem_req},    32'd0);
        check("lat2_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("lat3_valid",  {31'd0, instr_valid}, 32'd1);
        check("lat3_instr",  instr,                32'h0000_0001);
        check("lat3_opcode", {28'd0, opcode},      32'd0);
        check("lat3_pc",     instr_pc,             32'd0);
        check("lat3_addr",   imem_addr,            32'd4);

        // Back-pressure: buffer fills with PCs 0 and 4, then requests stop.
        tick();
        tick();
        check("stall_req", {31'd0, imem_req}, 32'd0);
        repeat (7) tick();
        check("hold_req",   {31'd0, imem_req},    32'd0);
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_pc",    instr_pc,             32'd0);
        check("hold_addr",  imem_addr,            32'd8);

        instr_ready = 1'b1;
        tick();
        check("drain_pc4",    instr_pc, 32'd4);
        check("drain_instr4", instr,    32'd5);
        tick();
        check("drain_empty", {31'd0, instr_valid}, 32'd0);
        tick();
        check("drain_pc8",    instr_pc, 32'd8);
        check("drain_instr8", instr,    32'd9);

        // Redirect while waiting on a delayed response.
        instr_ready = 1'b0;
        mem_auto    = 1'b0;
        tick();
        check("br_wait_req", {31'd0, imem_req}, 32'd0);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        tick();
        branch_taken = 1'b0;
        check("br_flush",     {31'd0, instr_valid}, 32'd0);
        check("br_block_req", {31'd0, imem_req},    32'd0);
        check("br_addr",      imem_addr,            32'h0000_0100);
        tick();
        check("br_still_block", {31'd0, imem_req}, 32'd0);
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_0000;
        tick();
        man_rvalid = 1'b0;
        check("br_drop",    {31'd0, instr_valid}, 32'd0);
        check("br_reissue", {31'd0, imem_req},    32'd1);
        check("br_raddr",   imem_addr,            32'h0000_0100);
        mem_auto = 1'b1;
        tick();
        tick();
        check("br_new_pc",    instr_pc, 32'h0000_0100);
        check("br_new_instr", instr,    32'h0000_0101);

        // Redirect coinciding with a pop and a same-cycle accepted request; then wrap.
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        check("wr_flush", {31'd0, instr_valid}, 32'd0);
        check("wr_block", {31'd0, imem_req},    32'd0);
        check("wr_addr",  imem_addr,            32'hFFFF_FFFC);
        tick();
        check("wr_drop",  {31'd0, instr_valid}, 32'd0);
        check("wr_req",   {31'd0, imem_req},    32'd1);
        tick();
        check("wr_next_addr", imem_addr, 32'd0);
        tick();
        check("wr_top_pc",     instr_pc,        32'hFFFF_FFFC);
        check("wr_top_opcode", {28'd0, opcode}, 32'hF);
        tick();
        tick();
        check("wr_zero_pc", instr_pc, 32'd0);

        // Reset pulse while a request is outstanding, then a stale response.
        instr_ready = 1'b0;
        mem_auto    = 1'b0;
        tick();
        check("mr_wait_req", {31'd0, imem_req}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, instr_valid}, 32'd0);
        check("mr_addr",  imem_addr,            32'd0);
        check("mr_count", fetch_count,          32'd0);
        tick();
        reset_n    = 1'b1;
        man_rvalid = 1'b1;
        man_rdata  = 32'h0BAD_0BAD;
        tick();
        check("mr_ign1_valid", {31'd0, instr_valid}, 32'd0);
        check("mr_fetch_addr", imem_addr,            32'd0);
        tick();
        man_rvalid = 1'b0;
        mem_auto   = 1'b1;
        check("mr_ign2_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("mr_restart_pc",    instr_pc, 32'd0);
        check("mr_restart_instr", instr,    32'd1);

        // 100 in-order pops from a clean reset.
        pops   = 0;
        cyc    = 0;
        exp_pc = 32'd0;
        while (pops < 100 && cyc < 1000) begin
            instr_ready = instr_valid;
            if (instr_valid) begin
                check("pop_order", instr_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            tick();
            cyc++;
        end
        instr_ready = 1'b0;
        check("pop_budget",  pops,        100);
        check("fetch_count", fetch_count, EXP_CNT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the instruction buffer depth and is fixed at 2 in this revision.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  fetch address, word aligned.
REQ-007 imem_ready  in  1  request accepted in this cycle when imem_req=1.
REQ-008 imem_rvalid  in  1  read data valid; responses return in request order.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 instr_valid  out  1  buffer head holds a valid instruction.
REQ-011 instr_ready  in  1  control/decode stage consumes the head this cycle.
REQ-012 instr  out  32  head instruction word.
REQ-013 instr_pc  out  32  address of the head instruction.
REQ-014 opcode  out  4  instr[31:28], driven to the control decoder.
REQ-015 branch_taken  in  1  single-cycle redirect pulse from execute.
REQ-016 branch_target  in  32  redirect address, sampled when branch_taken=1.
REQ-017 fetch_count  out  32  count of consumed instructions; see Configuration.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, WAIT and STALL.
REQ-019 IDLE lasts exactly one cycle after reset release, then goes to FETCH.
REQ-020 FETCH: imem_req=1, imem_addr=pc; on imem_ready go to WAIT and set pc<=pc+4, wrapping modulo 2^32.
REQ-021 WAIT: on imem_rvalid, push {imem_rdata, request address} into the buffer, then go to FETCH if a slot is free after this cycle's push/pop, else to STALL.
REQ-022 STALL: imem_req=0; return to FETCH in the cycle after occupancy drops below BUF_DEPTH.
REQ-023 At most one request SHALL be outstanding, and a request SHALL issue only when occupancy+outstanding < BUF_DEPTH, so a push never occurs while the buffer is full.
REQ-024 While in FETCH without imem_ready, imem_addr SHALL hold stable except on redirect.
REQ-025 The buffer is a FIFO: instr_valid=(occupancy!=0); a pop occurs on instr_valid&instr_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-026 instr_ready while instr_valid=0 SHALL have no effect.
REQ-027 On branch_taken the block SHALL:
  - flush the buffer;
  - set pc<=branch_target with bits [1:0] forced to 0;
  - enter FETCH the next cycle;
  - mark any outstanding or same-cycle-accepted request as discard, so its response is dropped without a push.
REQ-028 While a discard is pending, no new request SHALL issue until the discarded rvalid arrives.
REQ-029 When branch_taken coincides with a pop, the pop counts as a consumption; the flush overrides any same-cycle push.
REQ-030 Fetch latency: the first instr_valid rises no earlier than 3 cycles after reset release with zero-wait memory (IDLE, FETCH, WAIT).

Reset
REQ-031 While reset_n=0, all of the following SHALL hold:
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, opcode=0, fetch_count=0;
  - buffer empty, discard flag clear, FSM in IDLE, pc=RESET_PC.
REQ-032 Reset asserted mid-transaction SHALL abandon the outstanding request, and an rvalid arriving later SHALL be ignored until the first new request is accepted.

Configuration
REQ-033 With FETCH_PERF_COUNT_EN defined, fetch_count increments by 1 per pop, wraps at 2^32, and clears on reset.
REQ-034 Without FETCH_PERF_COUNT_EN, fetch_count SHALL be tied to 0, no counter register is inferred, and the port list is unchanged.

Verification
REQ-035 Reset release with imem_ready=1, rvalid one cycle after acceptance, rdata=32'h0000_0001 -> instr_valid=1 and opcode=0 by cycle 3, instr_pc=0, next imem_addr=4.
REQ-036 instr_ready=0 held for 10 cycles -> exactly 2 entries buffered (PCs 0 and 4), imem_req=0 in STALL; instr_ready=1 -> PCs 0, 4, 8 delivered in order.
REQ-037 branch_taken with target 32'h0000_0103 while in WAIT -> in-flight response dropped, buffer empty, next accepted imem_addr=32'h0000_0100.
REQ-038 pc=32'hFFFF_FFFC fetched -> next imem_addr=0 and instr_pc of the next instruction=0.
REQ-039 reset_n pulsed low during WAIT, then stale rvalid -> no push, instr_valid=0, restart at RESET_PC.
REQ-040 100 pops with FETCH_PERF_COUNT_EN defined -> fetch_count=100; same run without the macro -> fetch_count=0 throughout.
